// File: rtl/conv_pkg.sv
// conv_pkg: shared types, kernel weights and saturation helper for the 3x3 stream filter
package conv_pkg;
  typedef enum logic [1:0] {PASS, GAUSS, SOBX, SOBMAG} mode_t;
  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
  localparam int GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  localparam int SOBX_K [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  function automatic int sat(input int v, input int hi);
    return v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: SRAM read port and filtered-pixel output stream
interface conv3x3_stream_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W = 8
);
  logic CE, OE, WE, LB, UB;
  logic [ADDR_W-1:0] SramAddr;
  logic [15:0] SramDQ;
  logic out_valid, out_ready, out_last;
  logic [PIX_W-1:0] out_pix;
  modport master (output CE, OE, WE, LB, UB, SramAddr, out_valid, out_pix, out_last, input SramDQ, out_ready);
  modport slave (input CE, OE, WE, LB, UB, SramAddr, out_valid, out_pix, out_last, output SramDQ, out_ready);
endinterface

// File: rtl/conv3x3_stream_window3x3.sv
// window3x3: two row-deep line buffers feeding a 3x3 sliding window; row 2 is the newest line
module window3x3 #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic Clk,
  input  logic en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [2:0][2:0][PIX_W-1:0] win_o
);
  logic [IMG_W-1:0][PIX_W-1:0] lb1_q, lb2_q;
  logic [2:0][2:0][PIX_W-1:0] win_q;
  always_ff @(posedge Clk)
    if (en_i) begin
      lb1_q <= {lb1_q[IMG_W-2:0], din_i};
      lb2_q <= {lb2_q[IMG_W-2:0], lb1_q[IMG_W-1]};
      win_q[2] <= {din_i, win_q[2][2:1]};
      win_q[1] <= {lb1_q[IMG_W-1], win_q[1][2:1]};
      win_q[0] <= {lb2_q[IMG_W-1], win_q[0][2:1]};
    end
  assign win_o = win_q;
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-scans a frame from SRAM and streams one 3x3-filtered pixel per advancing cycle
module conv3x3_stream import conv_pkg::*; #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8,
  parameter int ADDR_W = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic start,
  input  logic [1:0] mode,
  output logic busy,
  output logic done,
  conv3x3_stream_if.master bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PMAX = (1 << PIX_W) - 1;
  localparam logic [ADDR_W-1:0] FILL_END = ADDR_W'(BASE_ADDR + IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE_ADDR + IMG_W * IMG_H - 1);
  state_t state_q, state_d;
  mode_t mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic fin_q, fin_d, valid_q, valid_d, last_q, last_d;
  logic [PIX_W-1:0] pix_q, pix_d, kern;
  logic [2:0][2:0][PIX_W-1:0] win;
  logic adv, load, shift, border, at_last;
  logic dq_unused;
  int gs, gx, gy, ax, ay;
  assign adv = !valid_q || bus.out_ready;
  assign load = adv && (state_q == RUN || (state_q == DRAIN && !fin_q));
  assign shift = adv && (state_q == FILL || state_q == RUN || state_q == DRAIN);
  assign border = ox_q == '0 || ox_q == XW'(IMG_W - 1) || oy_q == '0 || oy_q == YW'(IMG_H - 1);
  assign at_last = ox_q == XW'(IMG_W - 1) && oy_q == YW'(IMG_H - 1);
  assign dq_unused = &{1'b0, bus.SramDQ[15:PIX_W]};
  window3x3 #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_win (
    .Clk(Clk), .en_i(shift), .din_i(bus.SramDQ[PIX_W-1:0]), .win_o(win)
  );
  always_comb begin
    gs = 0;
    gx = 0;
    gy = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gs += GAUSS_K[r][c] * int'(win[r][c]);
        gx += SOBX_K[r][c] * int'(win[r][c]);
        gy += SOBX_K[c][r] * int'(win[r][c]);
      end
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
  end
  assign kern = mode_q == PASS ? win[1][1] : border ? '0 :
                mode_q == GAUSS ? PIX_W'(gs >> 4) : PIX_W'(sat(mode_q == SOBX ? ax : ax + ay, PMAX));
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    addr_d = addr_q;
    ox_d = ox_q;
    oy_d = oy_q;
    fin_d = fin_q;
    valid_d = valid_q;
    pix_d = pix_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        mode_d = mode_t'(mode);
        addr_d = ADDR_W'(BASE_ADDR);
        ox_d = '0;
        oy_d = '0;
        fin_d = 1'b0;
      end
      FILL: begin
        addr_d = addr_q + 1'b1;
        state_d = addr_q == FILL_END ? RUN : FILL;
      end
      RUN: if (adv) begin
        addr_d = addr_q == LAST_A ? addr_q : addr_q + 1'b1;
        state_d = addr_q == LAST_A ? DRAIN : RUN;
      end
      DRAIN: state_d = adv && fin_q ? DONE : DRAIN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // ox/oy always name the next output to be loaded, which is the window centre
    if (load) begin
      valid_d = 1'b1;
      pix_d = kern;
      last_d = at_last;
      fin_d = at_last;
      ox_d = ox_q == XW'(IMG_W - 1) ? '0 : ox_q + XW'(1);
      oy_d = ox_q == XW'(IMG_W - 1) ? oy_q + YW'(1) : oy_q;
    end else if (adv) valid_d = 1'b0;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      mode_q <= PASS;
      addr_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      fin_q <= 1'b0;
      valid_q <= 1'b0;
      pix_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      fin_q <= fin_d;
      valid_q <= valid_d;
      pix_q <= pix_d;
      last_q <= last_d;
    end
  assign bus.CE = !(state_q == FILL || state_q == RUN);
  assign bus.OE = bus.CE;
  assign bus.WE = 1'b1;
  assign bus.LB = 1'b0;
  assign bus.UB = 1'b0;
  assign bus.SramAddr = addr_q;
  assign bus.out_valid = valid_q;
  assign bus.out_pix = pix_q;
  assign bus.out_last = last_q;
  assign busy = state_q == FILL || state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: table vectors plus random frames checked against an arithmetic reference filter
module tb_conv3x3_stream;
  localparam int W = 8, H = 6, N = W * H;
  logic clk = 0, rst_n = 1, start = 0, busy, done;
  logic [1:0] mode = 0;
  logic [7:0] img [64];
  int n_chk = 0, n_fail = 0, cyc_g = 0;
  int done_cnt = 0, done_cyc = 0, hs_cyc = 0, stall_cnt = 0, stall_bad = 0;
  int rd_hits [64];
  int rd_base [64];
  logic [7:0] got_pix [$];
  bit got_last [$];
  logic p_stall = 0;
  logic [7:0] p_pix = 0;
  logic [19:0] p_addr = 0;
  conv3x3_stream_if #(.ADDR_W(20), .PIX_W(8)) bus ();
  conv3x3_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(20), .BASE_ADDR(0)) dut (
    .Clk(clk), .Reset_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done), .bus(bus.master)
  );
  always #5 clk = ~clk;
  assign bus.SramDQ = {8'hA5, img[bus.SramAddr[5:0]]};
  always @(posedge clk) cyc_g <= cyc_g + 1;
  always @(negedge clk) begin
    if (p_stall && (!bus.out_valid || bus.out_pix != p_pix || bus.SramAddr != p_addr)) stall_bad <= stall_bad + 1;
    if (bus.out_valid && !bus.out_ready) stall_cnt <= stall_cnt + 1;
    p_stall <= bus.out_valid && !bus.out_ready;
    p_pix <= bus.out_pix;
    p_addr <= bus.SramAddr;
    if (bus.out_valid && bus.out_ready) begin
      got_pix.push_back(bus.out_pix);
      got_last.push_back(bus.out_last);
      hs_cyc <= cyc_g;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_g;
    end
    if (!bus.CE) rd_hits[bus.SramAddr[5:0]] <= rd_hits[bus.SramAddr[5:0]] + 1;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic int px(input int x, input int y);
    return int'(img[y * W + x]);
  endfunction
  function automatic int model(input logic [1:0] m, input int x, input int y);
    int s = 0, gx = 0, gy = 0;
    if (m == 0) return px(x, y);
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 0;
    for (int d = -1; d <= 1; d++) begin
      gx += (d == 0 ? 2 : 1) * (px(x + 1, y + d) - px(x - 1, y + d));
      gy += (d == 0 ? 2 : 1) * (px(x + d, y + 1) - px(x + d, y - 1));
      for (int e = -1; e <= 1; e++) s += (d == 0 ? 2 : 1) * (e == 0 ? 2 : 1) * px(x + e, y + d);
    end
    if (m == 1) return s / 16;
    gx = gx < 0 ? -gx : gx;
    gy = gy < 0 ? -gy : gy;
    return m == 2 ? (gx > 255 ? 255 : gx) : (gx + gy > 255 ? 255 : gx + gy);
  endfunction
  task automatic load_img(input int kind);
    for (int i = 0; i < 64; i++) begin
      img[i] = kind == 0 ? 8'(i) : kind == 1 ? 8'd100 : kind == 2 ? (i == 3 * W + 3 ? 8'd255 : 8'd0) :
               kind == 3 ? ((i % W) >= 4 ? 8'd200 : 8'd0) : 8'($urandom_range(0, 255));
    end
  endtask
  task automatic run_frame(input logic [1:0] m, input bit bp, input bit inj);
    int c, d0, q0, sb0, st0;
    d0 = done_cnt;
    q0 = got_pix.size();
    sb0 = stall_bad;
    st0 = stall_cnt;
    rd_base = rd_hits;
    mode = m;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", int'(busy), 1);
    c = 0;
    while (done_cnt == d0 && c < 3000) begin
      if (bp) bus.out_ready = (c >= 20 && c < 30) ? 1'b0 : (c >= 30 ? 1'($urandom_range(0, 1)) : 1'b1);
      start = inj && c == 25;
      if (inj && c == 25) mode = 2'b11;
      @(posedge clk); #1;
      c++;
    end
    start = 0;
    bus.out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("out_count", got_pix.size() - q0, N);
    chk("done_latency", done_cyc - hs_cyc, 1);
    chk("stall_hold_violations", stall_bad - sb0, 0);
    if (bp) chk("stall_cycles_ge10", int'(stall_cnt - st0 >= 10), 1);
    for (int i = 0; i < N && q0 + i < got_pix.size(); i++) begin
      chk($sformatf("pix[%0d] mode %0d", i, m), int'(got_pix[q0 + i]), model(m, i % W, i / W));
      chk($sformatf("last[%0d]", i), int'(got_last[q0 + i]), int'(i == N - 1));
    end
  endtask
  typedef struct { logic [1:0] m; int kind; int x; int y; int exp; } vec_t;
  vec_t tv [15];
  initial begin
    int fb;
    tv[0] = '{2'd0, 0, 5, 4, 37};
    tv[1] = '{2'd0, 0, 0, 0, 0};
    tv[2] = '{2'd1, 1, 3, 2, 100};
    tv[3] = '{2'd1, 1, 0, 3, 0};
    tv[4] = '{2'd1, 1, 7, 5, 0};
    tv[5] = '{2'd1, 2, 3, 3, 63};
    tv[6] = '{2'd1, 2, 2, 3, 31};
    tv[7] = '{2'd1, 2, 2, 2, 15};
    tv[8] = '{2'd1, 2, 1, 1, 0};
    tv[9] = '{2'd2, 3, 3, 2, 255};
    tv[10] = '{2'd2, 3, 4, 4, 255};
    tv[11] = '{2'd2, 3, 2, 2, 0};
    tv[12] = '{2'd2, 3, 6, 1, 0};
    tv[13] = '{2'd3, 3, 3, 3, 255};
    tv[14] = '{2'd3, 3, 5, 3, 0};
    bus.out_ready = 1;
    for (int i = 0; i < 64; i++) begin
      img[i] = 0;
      rd_hits[i] = 0;
    end
    #1 rst_n = 0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_pix", int'(bus.out_pix), 0);
    chk("rst_last", int'(bus.out_last), 0);
    chk("rst_addr", int'(bus.SramAddr), 0);
    chk("rst_ctl", int'({bus.CE, bus.OE, bus.WE, bus.LB, bus.UB}), 5'b11100);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || tv[i].m != tv[i - 1].m || tv[i].kind != tv[i - 1].kind) begin
        load_img(tv[i].kind);
        run_frame(tv[i].m, 0, 0);
      end
      fb = got_pix.size() - N;
      chk($sformatf("vec%0d mode %0d (%0d,%0d)", i, tv[i].m, tv[i].x, tv[i].y),
          int'(got_pix[fb + tv[i].y * W + tv[i].x]), tv[i].exp);
    end
    load_img(0);
    run_frame(0, 0, 0);
    for (int a = 0; a < N; a++) chk($sformatf("reads_of_addr_%0d", a), rd_hits[a] - rd_base[a], 1);
    run_frame(0, 1, 0);
    mode = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (20) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_addr", int'(bus.SramAddr), 0);
    chk("midrst_ce", int'(bus.CE), 1);
    @(posedge clk); #1;
    rst_n = 1;
    run_frame(0, 0, 0);
    load_img(4);
    run_frame(1, 0, 1);
    for (int k = 0; k < 6; k++) begin
      load_img(4);
      run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
